// File: rtl/reg_space_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the register space.
interface reg_space_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          h_req;
  logic          h_cmd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;

  logic          s_req;
  logic          s_cmd;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ack;
  logic [DW-1:0] s_rdata;
  logic          s_drop;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  h_req, h_cmd, h_addr, h_wdata,
    output h_ack, h_rdata,
    input  s_req, s_cmd, s_addr, s_wdata,
    output s_ack, s_rdata, s_drop,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output h_req, h_cmd, h_addr, h_wdata,
    input  h_ack, h_rdata,
    output s_req, s_cmd, s_addr, s_wdata,
    input  s_ack, s_rdata, s_drop,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/reg_space_arbiter.sv
// Arbiter sharing one single-port register space between host and serial ports.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests, pick grant, latch command/address/data
// ISSUE  | drive one memory strobe from the latched access
// RDWAIT | memory read data valid, capture into granted port(s)
// DONE   | one-cycle ack to the granted port(s)
module reg_space_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  reg_space_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          gnt_h_q, gnt_s_q, drop_q;
  logic          h_ack_q, s_ack_q, s_drop_q;
  logic [DW-1:0] h_rdata_q, s_rdata_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          gnt_h_d, gnt_s_d, drop_d, cmd_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [CW-1:0] cnt_d;
  logic          same_addr, coll_wr, coll_rd;

  // Grant decision for the IDLE sampling cycle: collisions first, then starvation, then host priority.
  always_comb begin
    same_addr = (bus.h_addr == bus.s_addr);
    coll_wr   = bus.h_req & bus.s_req & same_addr & bus.h_cmd & bus.s_cmd;
    coll_rd   = bus.h_req & bus.s_req & same_addr & ~bus.h_cmd & ~bus.s_cmd;
    gnt_h_d   = 1'b0;
    gnt_s_d   = 1'b0;
    drop_d    = 1'b0;
    cnt_d     = cnt_q;
    if (coll_wr) begin
      gnt_h_d = 1'b1;
      gnt_s_d = 1'b1;
      drop_d  = 1'b1;
      cnt_d   = '0;
    end else if (coll_rd) begin
      gnt_h_d = 1'b1;
      gnt_s_d = 1'b1;
      cnt_d   = '0;
    end else if (bus.s_req && (cnt_q == CW'(STARVE_LIMIT))) begin
      gnt_s_d = 1'b1;
      cnt_d   = '0;
    end else if (bus.h_req) begin
      gnt_h_d = 1'b1;
      cnt_d   = bus.s_req ? cnt_q + CW'(1) : '0;
    end else if (bus.s_req) begin
      gnt_s_d = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d   = '0;
    end
    // On a merged collision the host side supplies the single access.
    cmd_d   = gnt_h_d ? bus.h_cmd   : bus.s_cmd;
    addr_d  = gnt_h_d ? bus.h_addr  : bus.s_addr;
    wdata_d = gnt_h_d ? bus.h_wdata : bus.s_wdata;
  end

  // Access sequencer with registered memory strobes, acks and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_h_q     <= 1'b0;
      gnt_s_q     <= 1'b0;
      drop_q      <= 1'b0;
      h_ack_q     <= 1'b0;
      s_ack_q     <= 1'b0;
      s_drop_q    <= 1'b0;
      h_rdata_q   <= '0;
      s_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= cnt_d;
          if (gnt_h_d || gnt_s_d) begin
            gnt_h_q     <= gnt_h_d;
            gnt_s_q     <= gnt_s_d;
            drop_q      <= drop_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= cmd_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          if (mem_we_q) begin
            h_ack_q  <= gnt_h_q;
            s_ack_q  <= gnt_s_q;
            s_drop_q <= drop_q;
            state_q  <= DONE;
          end else begin
            state_q  <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (gnt_h_q) h_rdata_q <= bus.mem_rdata;
          if (gnt_s_q) s_rdata_q <= bus.mem_rdata;
          h_ack_q <= gnt_h_q;
          s_ack_q <= gnt_s_q;
          state_q <= DONE;
        end
        DONE: begin
          h_ack_q  <= 1'b0;
          s_ack_q  <= 1'b0;
          s_drop_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.h_ack     = h_ack_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.s_ack     = s_ack_q;
  assign bus.s_rdata   = s_rdata_q;
  assign bus.s_drop    = s_drop_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_reg_space_arbiter.sv
// Scoreboard bench for reg_space_arbiter with a behavioural 256x16 register space.
module tb_reg_space_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_space_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  reg_space_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic        drop;
  } exp_t;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  exp_t        hq[$];
  exp_t        sq[$];
  int          ack_log[$];
  int          vecs = 0;
  int          errs = 0;
  int          mem_en_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] last_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous single-port memory: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // Ack monitor: pops the scoreboard and checks data/drop, counts memory strobes.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_en) begin
      mem_en_cnt++;
      if (bus.mem_we) begin
        wr_cnt++;
        last_wdata = bus.mem_wdata;
      end
    end
    if (bus.h_ack) begin
      ack_log.push_back(0);
      chk("h_ack_expected", (hq.size() != 0), 1);
      if (hq.size() != 0) begin
        e = hq.pop_front();
        if (e.rd) chk("h_rdata", bus.h_rdata, e.data);
      end
    end
    if (bus.s_ack) begin
      ack_log.push_back(1);
      chk("s_ack_expected", (sq.size() != 0), 1);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        if (e.rd) chk("s_rdata", bus.s_rdata, e.data);
        chk("s_drop", bus.s_drop, e.drop);
      end
    end
    if (bus.s_drop) chk("s_drop_without_ack", bus.s_ack, 1);
  end

  // One transaction from each enabled requester; host wins unless addresses merge.
  task automatic access(input logic he, input logic hc, input logic [7:0] ha, input logic [15:0] hw,
                        input logic se, input logic sc, input logic [7:0] sa, input logic [15:0] sw,
                        input string nm);
    exp_t e;
    bit   mwr, mrd, hd, sd;
    int   exp_mem, exp_wr, h_lat, s_lat, n, h_exp, s_exp;
    mwr = he && se && hc && sc && (ha == sa);
    mrd = he && se && !hc && !sc && (ha == sa);
    exp_mem = 0; exp_wr = 0; hd = 0; sd = 0; n = 0; h_lat = -1; s_lat = -1;
    if (he) begin
      e.rd = !hc; e.data = ref_mem[ha]; e.drop = 1'b0;
      if (hc) ref_mem[ha] = hw;
      hq.push_back(e);
      exp_mem++; exp_wr += int'(hc);
    end
    if (se) begin
      e.rd = !sc; e.data = ref_mem[sa]; e.drop = mwr;
      if (sc && !mwr) ref_mem[sa] = sw;
      sq.push_back(e);
      if (!mwr && !mrd) begin exp_mem++; exp_wr += int'(sc); end
    end
    h_exp = hc ? 2 : 3;
    if (mwr || mrd)     s_exp = h_exp;
    else if (he)        s_exp = h_exp + 1 + (sc ? 2 : 3);
    else                s_exp = sc ? 2 : 3;
    mem_en_cnt = 0; wr_cnt = 0;
    bus.h_req = he; bus.h_cmd = hc; bus.h_addr = ha; bus.h_wdata = hw;
    bus.s_req = se; bus.s_cmd = sc; bus.s_addr = sa; bus.s_wdata = sw;
    while (((he && !hd) || (se && !sd)) && n < 30) begin
      @(posedge clk); n++;
      #1;
      if (hd) bus.h_req = 1'b0;
      if (sd) bus.s_req = 1'b0;
      @(negedge clk);
      if (bus.h_ack && !hd) begin hd = 1; h_lat = n; end
      if (bus.s_ack && !sd) begin sd = 1; s_lat = n; end
    end
    @(posedge clk); #1;
    bus.h_req = 1'b0; bus.s_req = 1'b0;
    chk({nm, "_timeout"}, (n < 30), 1);
    if (he) chk({nm, "_h_lat"}, h_lat, h_exp);
    if (se) chk({nm, "_s_lat"}, s_lat, s_exp);
    chk({nm, "_mem_en_cnt"}, mem_en_cnt, exp_mem);
    chk({nm, "_mem_wr_cnt"}, wr_cnt, exp_wr);
    if (mwr) begin
      chk({nm, "_wdata"}, last_wdata, hw);
      chk({nm, "_mem"}, mem[ha], hw);
    end
  endtask

  // Waits for the serial ack with requests held; checks grant order in ack_log.
  task automatic hold_wait(input int nh, input string nm);
    int n;
    bit sd;
    n = 0; sd = 0;
    while (!sd && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.s_ack) sd = 1;
    end
    @(posedge clk); #1;
    bus.h_req = 1'b0; bus.s_req = 1'b0;
    chk({nm, "_timeout"}, (n < 100), 1);
    chk({nm, "_log_size"}, ack_log.size(), nh + 1);
    for (int i = 0; i < ack_log.size() && i <= nh; i++)
      chk({nm, "_order"}, ack_log[i], (i == nh) ? 1 : 0);
    chk({nm, "_hq_empty"}, hq.size(), 0);
    chk({nm, "_sq_empty"}, sq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   hc;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h0101);
      ref_mem[i] = 16'(i * 16'h0101);
    end
    mem[8'h40] = 16'h1234; ref_mem[8'h40] = 16'h1234;

    reset = 1'b1;
    bus.h_req = 1'b1; bus.h_cmd = 1'b1; bus.h_addr = 8'h01; bus.h_wdata = 16'hFFFF;
    bus.s_req = 1'b1; bus.s_cmd = 1'b0; bus.s_addr = 8'h02; bus.s_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_h_ack", bus.h_ack, 0);
    chk("rst_s_ack", bus.s_ack, 0);
    chk("rst_s_drop", bus.s_drop, 0);
    chk("rst_h_rdata", bus.h_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    bus.h_req = 1'b0; bus.s_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    access(1, 1, 8'h12, 16'hBEEF, 0, 0, 8'h00, 16'h0000, "h_wr");
    chk("h_wr_mem", mem[8'h12], 16'hBEEF);
    access(1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 16'h0000, "h_rd");
    access(0, 0, 8'h00, 16'h0000, 1, 0, 8'h40, 16'h0000, "s_rd");
    access(1, 1, 8'h05, 16'hAAAA, 1, 1, 8'h05, 16'h5555, "coll_wr");
    access(1, 0, 8'h07, 16'h0000, 1, 0, 8'h07, 16'h0000, "coll_rd");
    access(1, 1, 8'h09, 16'h9999, 1, 0, 8'h09, 16'h0000, "mix_hw_sr");
    access(1, 0, 8'h0A, 16'h0000, 1, 1, 8'h0A, 16'hA5A5, "mix_hr_sw");
    chk("mix_hr_sw_mem", mem[8'h0A], 16'hA5A5);
    access(1, 1, 8'h0B, 16'h0B0B, 1, 1, 8'h0C, 16'hC0C0, "both_wr_diff");
    chk("both_wr_diff_mem", mem[8'h0C], 16'hC0C0);
    access(0, 0, 8'h00, 16'h0000, 1, 1, 8'h0D, 16'hD00D, "s_wr");
    access(0, 0, 8'h00, 16'h0000, 1, 0, 8'h0D, 16'h0000, "s_rd_back");

    // Starvation: host write held, serial read pending at another address.
    ack_log.delete();
    ref_mem[8'h20] = 16'h2020;
    for (int i = 0; i < 4; i++) begin
      e.rd = 1'b0; e.data = '0; e.drop = 1'b0; hq.push_back(e);
    end
    e.rd = 1'b1; e.data = ref_mem[8'h21]; e.drop = 1'b0; sq.push_back(e);
    bus.h_req = 1'b1; bus.h_cmd = 1'b1; bus.h_addr = 8'h20; bus.h_wdata = 16'h2020;
    bus.s_req = 1'b1; bus.s_cmd = 1'b0; bus.s_addr = 8'h21; bus.s_wdata = '0;
    hold_wait(4, "starve");

    // Reset in RDWAIT with the starve counter part-way; counter must restart at zero.
    ack_log.delete();
    for (int i = 0; i < 2; i++) begin
      e.rd = 1'b1; e.data = ref_mem[8'h30]; e.drop = 1'b0; hq.push_back(e);
    end
    bus.h_req = 1'b1; bus.h_cmd = 1'b0; bus.h_addr = 8'h30; bus.h_wdata = '0;
    bus.s_req = 1'b1; bus.s_cmd = 1'b1; bus.s_addr = 8'h31; bus.s_wdata = 16'h5151;
    hc = 0;
    for (int n = 0; n < 50 && hc < 2; n++) begin
      @(negedge clk);
      if (bus.h_ack) hc++;
    end
    chk("rstmid_pre_acks", hc, 2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_en", bus.mem_en, 0);
    chk("rstmid_h_ack", bus.h_ack, 0);
    chk("rstmid_s_ack", bus.s_ack, 0);
    chk("rstmid_s_rdata", bus.s_rdata, 0);
    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      e.rd = 1'b1; e.data = ref_mem[8'h30]; e.drop = 1'b0; hq.push_back(e);
    end
    e.rd = 1'b0; e.data = '0; e.drop = 1'b0; sq.push_back(e);
    ref_mem[8'h31] = 16'h5151;
    hold_wait(4, "rstmid");
    chk("rstmid_mem", mem[8'h31], 16'h5151);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
